// File: rtl/branch_resolver_if.sv
// Execute-to-fetch branch bundle: ALU flags and branch decode in,
// PC, flush and the JM memory read port out.
interface branch_resolver_if #(
    parameter int unsigned PC_W = 32
);
    logic            in_flag_valid;
    logic            in_zero;
    logic            in_neg;
    logic            in_br_valid;
    logic [1:0]      in_br_type;
    logic [PC_W-1:0] in_target;
    logic            in_stall;
    logic            in_mem_ack;
    logic [PC_W-1:0] in_mem_data;
    logic [PC_W-1:0] out_pc;
    logic            out_flush;
    logic            out_busy;
    logic            out_mem_req;
    logic [PC_W-1:0] out_mem_addr;
    logic            out_zero_q;
    logic            out_neg_q;

    modport master (
        output in_flag_valid, in_zero, in_neg,
        output in_br_valid, in_br_type, in_target,
        output in_stall, in_mem_ack, in_mem_data,
        input  out_pc, out_flush, out_busy,
        input  out_mem_req, out_mem_addr,
        input  out_zero_q, out_neg_q
    );

    modport slave (
        input  in_flag_valid, in_zero, in_neg,
        input  in_br_valid, in_br_type, in_target,
        input  in_stall, in_mem_ack, in_mem_data,
        output out_pc, out_flush, out_busy,
        output out_mem_req, out_mem_addr,
        output out_zero_q, out_neg_q
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: flag register, PC, J/BRZ/BRN resolution and
// multi-cycle jump-to-memory over a req/ack read port.
module branch_resolver #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     PC_STEP     = 1,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter bit              FLAG_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_resolver_if.slave  bus
);
    localparam logic [1:0] BR_J  = 2'b00;
    localparam logic [1:0] BR_Z  = 2'b01;
    localparam logic [1:0] BR_N  = 2'b10;
    localparam logic [1:0] BR_JM = 2'b11;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    typedef enum logic {
        RUN,
        JM_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            flush_q, flush_d;
    logic            busy_q, busy_d;
    logic            req_q, req_d;
    logic            eff_zero;
    logic            eff_neg;
    logic            taken;

    // Bypass lets a flag-setting op and its dependent branch share a cycle
    assign eff_zero = (FLAG_BYPASS && bus.in_flag_valid) ?
                      bus.in_zero : zero_q;
    assign eff_neg  = (FLAG_BYPASS && bus.in_flag_valid) ?
                      bus.in_neg : neg_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        flush_d = 1'b0;
        busy_d  = busy_q;
        req_d   = req_q;
        taken   = 1'b0;

        if (bus.in_flag_valid) begin
            zero_d = bus.in_zero;
            neg_d  = bus.in_neg;
        end

        unique case (state_q)
            RUN: begin
                if (!bus.in_stall) begin
                    pc_d = pc_q + STEP;
                    if (bus.in_br_valid) begin
                        unique case (bus.in_br_type)
                            BR_J:  taken = 1'b1;
                            BR_Z:  taken = eff_zero;
                            BR_N:  taken = eff_neg;
                            BR_JM: begin
                                pc_d    = pc_q;
                                addr_d  = bus.in_target;
                                req_d   = 1'b1;
                                busy_d  = 1'b1;
                                state_d = JM_WAIT;
                            end
                        endcase
                        if (taken) begin
                            pc_d    = bus.in_target;
                            flush_d = 1'b1;
                        end
                    end
                end
            end
            JM_WAIT: begin
                if (bus.in_mem_ack) begin
                    pc_d    = bus.in_mem_data;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    flush_d = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
        end
    end

    assign bus.out_pc       = pc_q;
    assign bus.out_flush    = flush_q;
    assign bus.out_busy     = busy_q;
    assign bus.out_mem_req  = req_q;
    assign bus.out_mem_addr = addr_q;
    assign bus.out_zero_q   = zero_q;
    assign bus.out_neg_q    = neg_q;
endmodule
